// File: rtl/io_scan_pkg.sv
// Shared defaults and helpers for the IO scan harness.
package io_scan_pkg;

  localparam int unsigned DIN_N_DEF  = 160;
  localparam int unsigned DOUT_N_DEF = 160;
  localparam int unsigned FCNT_W_DEF = 16;

  // Width needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/io_scan_shreg.sv
// Serial-in / parallel-out shift register with a parallel load that wins over shifting.
module io_scan_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         shift_en,
  input  logic         load_en,
  input  logic [W-1:0] pdata,
  output logic [W-1:0] pout
);

  logic [W-1:0] shr_q, shr_d;

  always_comb begin
    shr_d = shr_q;
    if (load_en) begin
      shr_d = pdata;
    end else if (shift_en) begin
      shr_d = {shr_q[W-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shr_q <= '0;
    end else begin
      shr_q <= shr_d;
    end
  end

  assign pout = shr_q;

endmodule

// File: rtl/io_scan_harness.sv
// Scan harness: serial stimulus chain feeding a registered ROI input bus and a capture/unload chain.
// Optional auto-capture on the frame-completing shift when IO_SCAN_AUTOSTB_EN is defined.
module io_scan_harness
  import io_scan_pkg::*;
#(
  parameter int unsigned DIN_N  = DIN_N_DEF,
  parameter int unsigned DOUT_N = DOUT_N_DEF,
  parameter int unsigned FCNT_W = FCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              stb,
  input  logic              sdi,
  output logic              sdo,
  output logic [DIN_N-1:0]  din,
  input  logic [DOUT_N-1:0] dout,
  output logic              loaded,
  output logic              stb_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned CNT_W = cnt_width(DIN_N);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIN_N);

  logic [DIN_N-1:0]  din_shr;
  logic [DOUT_N-1:0] dout_shr;
  logic [DIN_N-1:0]  cap_src;
  logic              cap;

  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [DIN_N-1:0]  din_q, din_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              stb_err_q, stb_err_d;

  io_scan_shreg #(.W(DIN_N)) u_din_chain (
    .clk      (clk),
    .rst      (rst),
    .sin      (sdi),
    .shift_en (shift_en),
    .load_en  (1'b0),
    .pdata    ('0),
    .pout     (din_shr)
  );

  io_scan_shreg #(.W(DOUT_N)) u_dout_chain (
    .clk      (clk),
    .rst      (rst),
    .sin      (din_shr[DIN_N-1]),
    .shift_en (shift_en),
    .load_en  (cap),
    .pdata    (dout),
    .pout     (dout_shr)
  );

  assign loaded = (shift_cnt_q >= FULL);

`ifdef IO_SCAN_AUTOSTB_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIN_N - 1);
  logic auto_cap;
  // Auto capture fires while loaded is still low, so it never coincides with an
  // accepted external strobe; it latches the chain including the incoming bit.
  assign auto_cap = shift_en && (shift_cnt_q == LAST);
  assign cap      = (stb && loaded) || auto_cap;
  assign cap_src  = auto_cap ? {din_shr[DIN_N-2:0], sdi} : din_shr;
`else
  assign cap      = stb && loaded;
  assign cap_src  = din_shr;
`endif

  always_comb begin
    shift_cnt_d = shift_cnt_q;
    din_d       = din_q;
    frame_cnt_d = frame_cnt_q;
    stb_err_d   = stb_err_q;
    if (cap) begin
      din_d       = cap_src;
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      shift_cnt_d = shift_en ? CNT_W'(1) : '0;
    end else begin
      if (shift_en && !loaded) begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end
      if (stb) begin
        stb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt_q <= '0;
      din_q       <= '0;
      frame_cnt_q <= '0;
      stb_err_q   <= 1'b0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
      din_q       <= din_d;
      frame_cnt_q <= frame_cnt_d;
      stb_err_q   <= stb_err_d;
    end
  end

  assign sdo       = dout_shr[DOUT_N-1];
  assign din       = din_q;
  assign frame_cnt = frame_cnt_q;
  assign stb_err   = stb_err_q;

endmodule

// File: tb/tb_io_scan_harness.sv
// Scoreboard bench for io_scan_harness (DIN_N=DOUT_N=8, FCNT_W=4); honours IO_SCAN_AUTOSTB_EN.
module tb_io_scan_harness;

`ifdef IO_SCAN_AUTOSTB_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shift_en = 1'b0;
  logic       stb = 1'b0;
  logic       sdi = 1'b0;
  logic       sdo;
  logic [7:0] din;
  logic [7:0] dout = '0;
  logic       loaded;
  logic       stb_err;
  logic [3:0] frame_cnt;

  io_scan_harness #(.DIN_N(8), .DOUT_N(8), .FCNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .stb       (stb),
    .sdi       (sdi),
    .sdo       (sdo),
    .din       (din),
    .dout      (dout),
    .loaded    (loaded),
    .stb_err   (stb_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] din;
    logic       sdo;
    logic       loaded;
    logic       err;
    logic [3:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference state: frame bits held as plain integers.
  int m_in_bits, m_out_bits, m_din, m_cnt, m_fcnt, m_err;

  task automatic model_step(input bit r, input bit sh, input bit st, input bit s, input int d);
    bit full, autoc, capt;
    int next_in;
    if (r) begin
      m_in_bits = 0; m_out_bits = 0; m_din = 0; m_cnt = 0; m_fcnt = 0; m_err = 0;
      return;
    end
    full    = (m_cnt >= 8);
    autoc   = AUTO && sh && (m_cnt == 7);
    capt    = (st && full) || autoc;
    next_in = sh ? ((m_in_bits * 2 + s) % 256) : m_in_bits;
    if (capt) begin
      m_din      = autoc ? next_in : m_in_bits;
      m_out_bits = d;
      m_fcnt     = (m_fcnt + 1) % 16;
      m_cnt      = sh ? 1 : 0;
    end else begin
      if (sh) begin
        m_out_bits = (m_out_bits * 2 + m_in_bits / 128) % 256;
        if (m_cnt < 8) m_cnt = m_cnt + 1;
      end
      if (st) m_err = 1;
    end
    m_in_bits = next_in;
  endtask

  task automatic cycle(input bit r, input bit sh, input bit st, input bit s, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; shift_en = sh; stb = st; sdi = s; dout = d;
    model_step(r, sh, st, s, int'(d));
    e.din    = 8'(m_din);
    e.sdo    = (m_out_bits / 128) != 0;
    e.loaded = (m_cnt >= 8);
    e.err    = (m_err != 0);
    e.fcnt   = 4'(m_fcnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, 1'b0, b[i], 8'h00);
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'h00);
  endtask

  task automatic check_const(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every clock the DUT presents a new output state; compare against the queue.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {din, sdo, loaded, stb_err, frame_cnt};
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL scoreboard: got din=%h sdo=%b loaded=%b err=%b fcnt=%0d expected din=%h sdo=%b loaded=%b err=%b fcnt=%0d at %0t",
                   a.din, a.sdo, a.loaded, a.err, a.fcnt, e.din, e.sdo, e.loaded, e.err, e.fcnt, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    check_const("reset_din", 32'(din), 32'h0);
    check_const("reset_fcnt", 32'(frame_cnt), 32'h0);

    if (!AUTO) begin
      shift_byte(8'hA5);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check_const("capture_din", 32'(din), 32'hA5);
      check_const("capture_fcnt", 32'(frame_cnt), 32'd1);

      shift_byte(8'h00);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
      seq = 8'b0011_1100;
      check_const("unload_sdo0", 32'(sdo), 32'(seq[7]));
      for (int i = 1; i < 8; i++) begin
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_const("unload_sdo", 32'(sdo), 32'(seq[7-i]));
      end

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      shifts(5);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check_const("early_stb_err", 32'(stb_err), 32'd1);
      check_const("early_stb_fcnt", 32'(frame_cnt), 32'd0);
      check_const("early_stb_din", 32'(din), 32'h0);
      shifts(3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check_const("late_stb_fcnt", 32'(frame_cnt), 32'd1);
      check_const("late_stb_err", 32'(stb_err), 32'd1);

      shift_byte(8'h96);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h81);
      check_const("both_din", 32'(din), 32'h96);
      check_const("both_sdo", 32'(sdo), 32'd1);
      check_const("both_loaded", 32'(loaded), 32'd0);
      shifts(6);
      check_const("both_cnt_not_full", 32'(loaded), 32'd0);
      shifts(1);
      check_const("both_cnt_full", 32'(loaded), 32'd1);

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int f = 0; f < 17; f++) begin
        shift_byte(8'($urandom));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom));
      end
      check_const("fcnt_wrap", 32'(frame_cnt), 32'd1);
      shifts(4);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
      check_const("midload_rst", 32'({din, sdo, loaded, stb_err, frame_cnt}), 32'h0);
      shifts(7);
      check_const("refill_partial", 32'(loaded), 32'd0);
      shifts(1);
      check_const("refill_full", 32'(loaded), 32'd1);
    end else begin
      shift_byte(8'hA5);
      check_const("auto_din", 32'(din), 32'hA5);
      check_const("auto_fcnt", 32'(frame_cnt), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      shifts(7);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      check_const("auto_ext_fcnt", 32'(frame_cnt), 32'd1);
    end

    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/io_scan_harness.md
IO_SCAN_HARNESS -- requirements
Module: io_scan_harness

Interface
REQ-001 SHALL have parameter DIN_N, default 160: width of the parallel stimulus bus driven into the ROI (2..1024).
REQ-002 SHALL have parameter DOUT_N, default 160: width of the parallel response bus captured from the ROI (2..1024).
REQ-003 SHALL have parameter FCNT_W, default 16: width of the frame counter.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port shift_en, input, 1: advances both shift chains by one bit.
REQ-007 SHALL have port stb, input, 1: capture request.
REQ-008 SHALL have port sdi, input, 1: serial stimulus in.
REQ-009 SHALL have port sdo, output, 1: serial response out, equal to dout_shr[DOUT_N-1].
REQ-010 SHALL have port din, output, DIN_N: registered stimulus to the ROI.
REQ-011 SHALL have port dout, input, DOUT_N: response from the ROI.
REQ-012 SHALL have port loaded, output, 1: high when shift_cnt >= DIN_N.
REQ-013 SHALL have port stb_err, output, 1: sticky flag for a rejected strobe.
REQ-014 SHALL have port frame_cnt, output, FCNT_W: count of accepted captures.

Function
REQ-015 SHALL, when shift_en=1, load din_shr <= {din_shr[DIN_N-2:0], sdi} and dout_shr <= {dout_shr[DOUT_N-2:0], din_shr[DIN_N-1]}.
REQ-016 SHALL keep shift_cnt, width clog2(DIN_N+1), incrementing on each shift and saturating at DIN_N.
REQ-017 SHALL accept a capture when stb=1 and loaded=1.
REQ-018 SHALL, on an accepted capture: din <= din_shr (pre-shift value); dout_shr <= dout, overriding the shift; frame_cnt += 1, wrapping modulo 2^FCNT_W; shift_cnt <= shift_en ? 1 : 0.
REQ-019 SHALL, for stb=1 with loaded=0, leave din, dout_shr and frame_cnt unchanged and set stb_err=1 until rst.
REQ-020 SHALL make din visible exactly 1 cycle after the accepting edge.
REQ-021 SHALL make dout[DOUT_N-1] visible on sdo 1 cycle after capture, with subsequent bits following one per shift.
REQ-022 SHALL, with stb=1 and shift_en=1 in the same cycle, let din_shr shift normally while capture wins on dout_shr.
REQ-023 SHALL hold all state when shift_en=0 and stb=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear din_shr, dout_shr, din, shift_cnt, frame_cnt and stb_err; sdo=0 and loaded=0 the following cycle.
REQ-025 SHALL give rst priority over shift_en and stb, including reset mid-load; a partial frame is discarded.

Configuration
REQ-026 SHALL use macro IO_SCAN_AUTOSTB_EN.
REQ-027 SHALL, when IO_SCAN_AUTOSTB_EN is defined, generate an internal capture on the edge where shift_cnt goes from DIN_N-1 to DIN_N; it is ORed with stb, counts once per cycle, and evaluates that capture with din_shr including the DIN_N-th bit.
REQ-028 SHALL, when IO_SCAN_AUTOSTB_EN is undefined, capture only on external stb; there is no auto logic.

Structure
REQ-029 SHALL place default DIN_N/DOUT_N/FCNT_W constants and a clog2-based counter-width function in package io_scan_pkg.
REQ-030 SHALL implement the shift chains with sub-module io_scan_shreg (parameter W; ports: serial in, shift enable, parallel load enable, parallel data; parallel out), instantiated twice.

Verification (DIN_N=DOUT_N=8, FCNT_W=4, unless noted)
REQ-031 SHALL check: shift 8'hA5 MSB-first, then stb -> din=8'hA5 next cycle, frame_cnt=1.
REQ-032 SHALL check: dout=8'h3C, accepted stb, then 8 shifts -> sdo sequence 0,0,1,1,1,1,0,0.
REQ-033 SHALL check: stb after 5 shifts -> din unchanged, stb_err=1, frame_cnt=0; stb after 3 more shifts -> accepted, stb_err still 1.
REQ-034 SHALL check: stb and shift_en together on a loaded frame -> din takes the pre-shift value, shift_cnt=1, dout_shr=dout.
REQ-035 SHALL check: 17 accepted frames -> frame_cnt=1 (wrap); rst after 4 shifts -> all outputs 0, and a further 8 shifts are needed for loaded=1.
REQ-036 SHALL check, with IO_SCAN_AUTOSTB_EN defined: 8 continuous shifts -> capture on the 8th edge, din valid the next cycle, frame_cnt=1; external stb on the same cycle -> frame_cnt=1.
